uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/uart_tx_arb_rr_pick.sv | 32 +++
 rtl/uart_tx_arb.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// header byte base, and an index-width helper.
// Optional feature macro: UART_ARB_HDR_EN (header byte before each packet).
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  // Header byte is HDR_BASE with the owning channel index OR-ed into the low bits
  localparam logic [7:0] HDR_BASE = 8'hA0;

  // Width needed to hold an index in 0..n-1, never less than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector. The search starts one past the last
// granted channel and wraps, so the most recently served channel has the
// lowest priority. Output is one-hot, or all zero when nothing requests.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int IW   = idx_w(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [N_CH-1:0] o_gnt
);

  logic          found;
  logic [IW-1:0] idx;

  // Walk channels last+1 .. last+N_CH (mod N_CH); first requester wins
  always_comb begin
    o_gnt = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = IW'((int'(i_last) + i) % N_CH);
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates N_CH byte-stream requesters onto one UART transmitter.
// A granted channel owns the link for a whole packet (until a last byte or
// MAX_LEN bytes), then the link idles for GAP_CYC cycles before the next
// round-robin grant. Owner stalls are waited out; no preemption.
// Optional feature macro: UART_ARB_HDR_EN -- when defined, each packet is
// preceded by a header byte HDR_BASE | channel index.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DATA_BIT = 8,
  parameter int MAX_LEN  = 64,
  parameter int GAP_CYC  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_CH-1:0]          i_req_valid,
  input  logic [N_CH*DATA_BIT-1:0] i_req_data,
  input  logic [N_CH-1:0]          i_req_last,
  output logic [N_CH-1:0]          o_req_ready,
  output logic [DATA_BIT-1:0]      o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [N_CH-1:0]          o_grant,
  output logic                     o_busy,
  output logic                     o_err_len
);

  localparam int IW = idx_w(N_CH);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int GW = idx_w(GAP_CYC + 1);

  arb_state_e          state, state_n;
  logic [N_CH-1:0]     grant, grant_n;
  logic [IW-1:0]       gidx, gidx_n;
  logic [IW-1:0]       last_grant, last_n;
  logic [CW-1:0]       byte_cnt, cnt_n, cnt_inc;
  logic [GW-1:0]       gap_cnt, gap_n;

  logic [N_CH-1:0]     pick;
  logic [IW-1:0]       pick_idx;
  logic                own_vld, own_last, accept;
  logic [DATA_BIT-1:0] own_data;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .i_req  (i_req_valid),
    .i_last (last_grant),
    .o_gnt  (pick)
  );

  // One-hot pick to index, so the grant index is registered alongside the mask
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_CH; i++)
      if (pick[i]) pick_idx = IW'(i);
  end

  // Granted channel's request, muxed straight through to the UART side
  assign own_vld  = i_req_valid[gidx];
  assign own_last = i_req_last[gidx];
  assign own_data = i_req_data[int'(gidx)*DATA_BIT +: DATA_BIT];
  assign cnt_inc  = byte_cnt + 1'b1;

  // Next-state and link outputs; registers hold unless a case overrides
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    gidx_n     = gidx;
    last_n     = last_grant;
    cnt_n      = byte_cnt;
    gap_n      = gap_cnt;
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    accept     = 1'b0;
    o_err_len  = 1'b0;
    case (state)
      IDLE: begin
        if (|i_req_valid) begin
          grant_n = pick;
          gidx_n  = pick_idx;
          cnt_n   = '0;
`ifdef UART_ARB_HDR_EN
          state_n = HDR;
`else
          state_n = DATA;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      HDR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = DATA_BIT'(HDR_BASE) | DATA_BIT'(gidx);
        if (i_tx_ready) state_n = DATA;
      end
`endif
      DATA: begin
        // A dropped valid simply stalls here with the grant held
        o_tx_valid = own_vld;
        o_tx_data  = own_data;
        accept     = i_tx_ready & own_vld;
        if (accept) begin
          cnt_n = cnt_inc;
          if (own_last || cnt_inc == CW'(MAX_LEN)) begin
            o_err_len = ~own_last;
            last_n    = gidx;
            grant_n   = '0;
            if (GAP_CYC > 0) begin
              state_n = GAP;
              gap_n   = GW'(GAP_CYC - 1);
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = IDLE;
        else               gap_n   = gap_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and bookkeeping registers; reset leaves channel 0 next in line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      last_grant <= IW'(N_CH - 1);
      byte_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      gidx       <= gidx_n;
      last_grant <= last_n;
      byte_cnt   <= cnt_n;
      gap_cnt    <= gap_n;
    end
  end

  assign o_req_ready = accept ? grant : '0;
  assign o_grant     = grant;
  assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
`timescale 1ns/1ps
module tb_uart_tx_arb;
  import uart_arb_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int ML  = 64;
  localparam int GAP = 16;
`ifdef UART_ARB_HDR_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [N-1:0]  i_req_valid, i_req_last, o_req_ready, o_grant;
  logic [N*DW-1:0] i_req_data;
  logic [DW-1:0] o_tx_data;
  logic          o_tx_valid, i_tx_ready, o_busy, o_err_len;

  // second instance: no gap, for back-to-back packets
  logic [N-1:0]  b_valid, b_last, b_ready, b_grant;
  logic [N*DW-1:0] b_data;
  logic [DW-1:0] b_txd;
  logic          b_txv, b_txr, b_busy, b_err;

  always #5 i_clk = ~i_clk;

  uart_tx_arb #(.N_CH(N), .DATA_BIT(DW), .MAX_LEN(ML), .GAP_CYC(GAP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_last(i_req_last),
    .o_req_ready(o_req_ready), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready), .o_grant(o_grant), .o_busy(o_busy), .o_err_len(o_err_len)
  );

  uart_tx_arb #(.N_CH(N), .DATA_BIT(DW), .MAX_LEN(ML), .GAP_CYC(0)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(b_valid), .i_req_data(b_data), .i_req_last(b_last),
    .o_req_ready(b_ready), .o_tx_data(b_txd), .o_tx_valid(b_txv),
    .i_tx_ready(b_txr), .o_grant(b_grant), .o_busy(b_busy), .o_err_len(b_err)
  );

  // requester byte sources and scoreboard
  logic [DW-1:0] src_d [N][128];
  logic          src_l [N][128];
  int            src_len [N];
  int            src_ptr [N];
  int            rdy_cnt [N];
  logic [N-1:0]  hold;
  int            uart_dly, ucnt;
  int            err_pulses, err_at;
  logic [11:0]   sbq[$];   // {channel, byte} in expected UART order
  int            cmp_cnt, mis_cnt;

  task automatic tick();
    @(negedge i_clk); #4.5;
  endtask

  task automatic load(input int ch, input logic [DW-1:0] d, input logic last);
    src_d[ch][src_len[ch]] = d;
    src_l[ch][src_len[ch]] = last;
    src_len[ch]++;
  endtask

  task automatic exp_byte(input int ch, input logic [DW-1:0] d);
    sbq.push_back({4'(ch), d});
  endtask

  task automatic exp_hdr(input int ch);
    if (HDR_ON) sbq.push_back({4'(ch), HDR_BASE | 8'(ch)});
  endtask

  function automatic bit all_done();
    bit d;
    d = (sbq.size() == 0) && !o_busy;
    for (int c = 0; c < N; c++) if (src_ptr[c] < src_len[c]) d = 0;
    return d;
  endfunction

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (all_done()) begin ok = 1; break; end
    end
  endtask

  task automatic do_reset();
    i_rst_n = 0;
    hold = '0;
    uart_dly = 1;
    err_pulses = 0;
    err_at = 0;
    sbq.delete();
    for (int c = 0; c < N; c++) begin src_len[c] = 0; src_ptr[c] = 0; rdy_cnt[c] = 0; end
    repeat (2) tick();
    i_rst_n = 1;
  endtask

  // Requester + UART model + scoreboard: drive at negedge+1, UART ready at
  // negedge+2, sample just before the capturing posedge.
  initial begin
    logic [11:0]  e;
    logic [N-1:0] eg;
    ucnt = 0;
    forever begin
      @(negedge i_clk); #1;
      for (int c = 0; c < N; c++) begin
        if (src_ptr[c] < src_len[c] && !hold[c]) begin
          i_req_valid[c] = 1'b1;
          i_req_data[c*DW +: DW] = src_d[c][src_ptr[c]];
          i_req_last[c] = src_l[c][src_ptr[c]];
        end else begin
          i_req_valid[c] = 1'b0;
          i_req_last[c]  = 1'b0;
        end
      end
      #1;
      i_tx_ready = 1'b0;
      if (o_tx_valid && i_rst_n) begin
        ucnt++;
        if (ucnt >= uart_dly) begin i_tx_ready = 1'b1; ucnt = 0; end
      end else ucnt = 0;
      #2;
      if (i_rst_n) begin
        for (int c = 0; c < N; c++)
          if (o_req_ready[c]) begin rdy_cnt[c]++; src_ptr[c]++; end
        if (o_err_len) begin err_pulses++; err_at = rdy_cnt[2]; end
        if (o_tx_valid && i_tx_ready) begin
          cmp_cnt++;
          if (sbq.size() == 0) begin
            mis_cnt++;
            $display("FAIL sb_extra: got grant=%b data=%h, expected no byte", o_grant, o_tx_data);
          end else begin
            e = sbq.pop_front();
            eg = '0;
            eg[e[11:8]] = 1'b1;
            if ({o_grant, o_tx_data} !== {eg, e[7:0]}) begin
              mis_cnt++;
              $display("FAIL sb_byte: got grant=%b data=%h, expected grant=%b data=%h",
                       o_grant, o_tx_data, eg, e[7:0]);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    i_rst_n = 0;
    load(1, 8'h77, 1'b1);   // request present while held in reset
    repeat (3) tick();
    cmp_cnt++; if (o_grant !== 4'b0)     begin mis_cnt++; $display("FAIL rst_grant: got %b, expected 0000", o_grant); end
    cmp_cnt++; if (o_busy !== 1'b0)      begin mis_cnt++; $display("FAIL rst_busy: got %b, expected 0", o_busy); end
    cmp_cnt++; if (o_tx_valid !== 1'b0)  begin mis_cnt++; $display("FAIL rst_txv: got %b, expected 0", o_tx_valid); end
    cmp_cnt++; if (o_tx_data !== 8'h00)  begin mis_cnt++; $display("FAIL rst_txd: got %h, expected 00", o_tx_data); end
    cmp_cnt++; if (o_req_ready !== 4'b0) begin mis_cnt++; $display("FAIL rst_rdy: got %b, expected 0000", o_req_ready); end
    cmp_cnt++; if (o_err_len !== 1'b0)   begin mis_cnt++; $display("FAIL rst_err: got %b, expected 0", o_err_len); end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    uart_dly = 3;
    load(1, 8'h11, 1'b0); load(1, 8'h22, 1'b1);
    exp_hdr(1); exp_byte(1, 8'h11); exp_byte(1, 8'h22);
    for (int k = 0; k < 100 && src_ptr[1] < 2; k++) tick();
    cmp_cnt++; if (src_ptr[1] !== 2) begin mis_cnt++; $display("FAIL single_done: got %0d bytes, expected 2", src_ptr[1]); end
    n = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!o_busy) break;
      n++;
    end
    cmp_cnt++; if (n !== GAP)        begin mis_cnt++; $display("FAIL single_gap: got %0d busy cycles, expected %0d", n, GAP); end
    cmp_cnt++; if (rdy_cnt[1] !== 2) begin mis_cnt++; $display("FAIL single_rdy: got %0d pulses, expected 2", rdy_cnt[1]); end
    cmp_cnt++; if (sbq.size() !== 0) begin mis_cnt++; $display("FAIL single_sb: got %0d left, expected 0", sbq.size()); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    for (int c = 0; c < N; c++) load(c, 8'(8'hC0 + c), 1'b1);
    load(0, 8'hD0, 1'b1);
    for (int c = 0; c < N; c++) begin exp_hdr(c); exp_byte(c, 8'(8'hC0 + c)); end
    exp_hdr(0); exp_byte(0, 8'hD0);
    wait_done(600, ok);
    cmp_cnt++; if (ok !== 1'b1)      begin mis_cnt++; $display("FAIL rr_done: got %0d left, expected 0", sbq.size()); end
    cmp_cnt++; if (rdy_cnt[0] !== 2) begin mis_cnt++; $display("FAIL rr_ch0: got %0d pulses, expected 2", rdy_cnt[0]); end
  endtask

  task automatic test_max_len();
    bit ok;
    do_reset();
    exp_hdr(2);
    for (int k = 0; k < ML; k++) begin load(2, 8'(k), 1'b0); exp_byte(2, 8'(k)); end
    load(2, 8'hEE, 1'b1);
    exp_hdr(2); exp_byte(2, 8'hEE);
    wait_done(600, ok);
    cmp_cnt++; if (ok !== 1'b1)         begin mis_cnt++; $display("FAIL len_done: got %0d left, expected 0", sbq.size()); end
    cmp_cnt++; if (err_pulses !== 1)    begin mis_cnt++; $display("FAIL len_err: got %0d pulses, expected 1", err_pulses); end
    cmp_cnt++; if (err_at !== ML)       begin mis_cnt++; $display("FAIL len_at: got byte %0d, expected %0d", err_at, ML); end
    cmp_cnt++; if (rdy_cnt[2] !== ML+1) begin mis_cnt++; $display("FAIL len_rdy: got %0d, expected %0d", rdy_cnt[2], ML+1); end
  endtask

  task automatic test_owner_stall();
    bit ok;
    do_reset();
    for (int k = 1; k <= 4; k++) begin load(0, 8'(k), k == 4); end
    load(3, 8'h3C, 1'b1);
    exp_hdr(0);
    for (int k = 1; k <= 4; k++) exp_byte(0, 8'(k));
    exp_hdr(3); exp_byte(3, 8'h3C);
    for (int k = 0; k < 100 && src_ptr[0] < 2; k++) tick();
    hold[0] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      cmp_cnt++;
      if (o_grant !== 4'b0001) begin mis_cnt++; $display("FAIL stall_grant: got %b, expected 0001", o_grant); end
    end
    cmp_cnt++; if (rdy_cnt[3] !== 0) begin mis_cnt++; $display("FAIL stall_ch3: got %0d pulses, expected 0", rdy_cnt[3]); end
    hold[0] = 1'b0;
    wait_done(200, ok);
    cmp_cnt++; if (ok !== 1'b1)      begin mis_cnt++; $display("FAIL stall_done: got %0d left, expected 0", sbq.size()); end
    cmp_cnt++; if (rdy_cnt[3] !== 1) begin mis_cnt++; $display("FAIL stall_ch3b: got %0d pulses, expected 1", rdy_cnt[3]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    uart_dly = 3;
    for (int k = 1; k <= 4; k++) load(2, 8'(8'h50 + k), k == 4);
    exp_hdr(2); exp_byte(2, 8'h51);
    for (int k = 0; k < 100 && src_ptr[2] < 1; k++) tick();
    tick();                 // byte 2 presented, not yet acknowledged
    i_rst_n = 0;
    #0.2;
    cmp_cnt++; if ({o_grant, o_busy, o_tx_valid, o_req_ready, o_err_len} !== '0)
      begin mis_cnt++; $display("FAIL mid_rst_ctl: got grant=%b busy=%b txv=%b rdy=%b err=%b, expected zeros",
                                o_grant, o_busy, o_tx_valid, o_req_ready, o_err_len); end
    cmp_cnt++; if (o_tx_data !== 8'h00) begin mis_cnt++; $display("FAIL mid_rst_txd: got %h, expected 00", o_tx_data); end
    cmp_cnt++; if (sbq.size() !== 0)    begin mis_cnt++; $display("FAIL mid_rst_sb: got %0d left, expected 0", sbq.size()); end
    src_len[2] = src_ptr[2];
    repeat (2) tick();
    load(2, 8'h2A, 1'b1); load(0, 8'h0A, 1'b1);
    exp_hdr(0); exp_byte(0, 8'h0A); exp_hdr(2); exp_byte(2, 8'h2A);
    i_rst_n = 1;
    wait_done(200, ok);
    cmp_cnt++; if (ok !== 1'b1) begin mis_cnt++; $display("FAIL mid_rst_after: got %0d left, expected 0", sbq.size()); end
  endtask

  task automatic test_back_to_back();
    int pulses, run, max_run, hdrs, errs;
    b_valid = 4'b0010; b_last = 4'b0010; b_data = 32'h0000_5A00; b_txr = 1'b1;
    for (int k = 0; k < 10 && b_grant == '0; k++) tick();
    pulses = 0; run = 0; max_run = 0; hdrs = 0; errs = 0;
    for (int t = 0; t < 40; t++) begin
      if (b_ready[1]) pulses++;
      if (b_txv && b_txd !== 8'h5A) hdrs++;
      if (b_err) errs++;
      if (!b_busy) begin run++; if (run > max_run) max_run = run; end else run = 0;
      tick();
    end
    b_valid = '0; b_last = '0; b_txr = 1'b0;
    cmp_cnt++; if (pulses !== (HDR_ON ? 13 : 20)) begin mis_cnt++; $display("FAIL b2b_bytes: got %0d, expected %0d", pulses, HDR_ON ? 13 : 20); end
    cmp_cnt++; if (max_run !== 1) begin mis_cnt++; $display("FAIL b2b_idle: got %0d idle cycles, expected 1", max_run); end
    cmp_cnt++; if (hdrs !== (HDR_ON ? 14 : 0)) begin mis_cnt++; $display("FAIL b2b_hdr: got %0d, expected %0d", hdrs, HDR_ON ? 14 : 0); end
    cmp_cnt++; if (errs !== 0) begin mis_cnt++; $display("FAIL b2b_err: got %0d, expected 0", errs); end
  endtask

  initial begin
    cmp_cnt = 0; mis_cnt = 0;
    i_rst_n = 0; i_tx_ready = 0;
    i_req_valid = '0; i_req_last = '0; i_req_data = '0;
    b_valid = '0; b_last = '0; b_data = '0; b_txr = 1'b0;
    hold = '0; uart_dly = 1; err_pulses = 0; err_at = 0;
    for (int c = 0; c < N; c++) begin src_len[c] = 0; src_ptr[c] = 0; rdy_cnt[c] = 0; end
    test_reset();
    test_single();
    test_round_robin();
    test_max_len();
    test_owner_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
